imm_gen_pipe: RTL and testbench

- Registered, parametrised immediate generator for the decode stage of the 5-stage RV pipeline.
- Decodes all base immediate formats (I, S, B, U, J, plus R = none) from a 32-bit instruction and sign-extends to XLEN.
- Flags illegal opcodes and passes the instruction alongside the immediate.
- Valid/ready handshake on both sides, optional skid buffer for full throughput under backpressure, and a flush input for branch redirects.

---
 rtl/imm_gen_pipe_pkg.sv | 27 ++
 rtl/imm_gen_pipe_decode.sv | 55 +++++
 rtl/imm_gen_pipe.sv | 87 ++++++++
 tb/tb_imm_gen_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants and format codes for the RV immediate generator.
package rv_imm_pkg;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> immediate/format decoder, sign-extended to XLEN.
module imm_decode_comb
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        fmt   = FMT_ILL;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_OPIMM32: begin
                if (XLEN == 64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP:   fmt = FMT_R;
            OPC_OP32: if (XLEN == 64) fmt = FMT_R;
            default: ;
        endcase
        illegal = (fmt == FMT_ILL);
        // Illegal and R leave imm32 at zero, so the upper fill is zero too.
        imm       = {XLEN{imm32[31]}};
        imm[31:0] = imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decoder, output register, optional skid, flush.
module imm_gen_pipe
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 64,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [31:0]     instr;
    } ent_t;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;
    ent_t            dec, out_q, skid_q;
    logic            out_v, skid_v, xfer;

    imm_decode_comb #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    assign dec = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_ill, instr: in_instr};

    generate
        if (SKID) begin : g_skid
            assign in_ready = !skid_v;
        end else begin : g_noskid
            assign in_ready = !out_v || out_ready;
        end
    endgenerate

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (!out_v || out_ready) begin
            // Output slot frees up: skid has priority (in_ready is low while it is full).
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (xfer) begin
                out_q <= dec;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (xfer && SKID) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign out_valid   = out_v;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
    assign out_instr   = out_q.instr;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench: XLEN=64/SKID=1 instance against a 2-deep FIFO model, plus XLEN=32/SKID=0 directed checks.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_instr;

    logic        f32, v32, ordy32;
    logic [31:0] ins32;
    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, oinstr32;
    logic [2:0]  fmt32;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .SKID(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_instr(out_instr)
    );

    imm_gen_pipe #(.XLEN(32), .SKID(1'b0)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(f32), .in_valid(v32), .in_ready(rdy32),
        .in_instr(ins32), .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32),
        .out_fmt(fmt32), .out_illegal(ill32), .out_instr(oinstr32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode straight from the format rules.
    function automatic void ref_dec(input logic [31:0] ins, input int xl,
                                    output logic [63:0] imm, output logic [2:0] fmt);
        longint v = 0;
        fmt = 3'd7;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin fmt = 3'd1; v = longint'($signed(ins[31:20])); end
            7'h1B: if (xl == 64) begin fmt = 3'd1; v = longint'($signed(ins[31:20])); end
            7'h23: begin fmt = 3'd2; v = longint'($signed({ins[31:25], ins[11:7]})); end
            7'h63: begin fmt = 3'd3; v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
            7'h37, 7'h17: begin fmt = 3'd4; v = longint'($signed({ins[31:12], 12'h000})); end
            7'h6F: begin fmt = 3'd5; v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
            7'h33: fmt = 3'd0;
            7'h3B: if (xl == 64) fmt = 3'd0;
            default: ;
        endcase
        imm = v;
        if (xl == 32) imm[63:32] = 32'h0;
    endfunction

    task automatic model_cmp();
        logic [63:0] ei;
        logic [2:0]  ef;
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() != 0) begin
            ref_dec(q[0], 64, ei, ef);
            chk("out_imm", out_imm, ei);
            chk("out_fmt", {61'd0, out_fmt}, {61'd0, ef});
            chk("out_illegal", {63'd0, out_illegal}, {63'd0, ef == 3'd7});
            chk("out_instr", {32'd0, out_instr}, {32'd0, q[0]});
        end
    endtask

    // Drive one cycle of inputs, advance the FIFO model across the edge, then compare.
    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        logic rdy;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        rdy = q.size() < 2;
        if (fl) q.delete();
        else begin
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (v && rdy) q.push_back(ins);
        end
        @(negedge clk);
        model_cmp();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[12] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h67,
                                 7'h6F, 7'h37, 7'h17, 7'h33, 7'h3B, 7'h73};
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    task automatic step32(input logic [31:0] ins);
        logic [63:0] ei;
        logic [2:0]  ef;
        v32 = 1'b1; ins32 = ins; ordy32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        ref_dec(ins, 32, ei, ef);
        chk("x32_valid", {63'd0, ov32}, 64'd1);
        chk("x32_imm", {32'd0, imm32}, ei);
        chk("x32_fmt", {61'd0, fmt32}, {61'd0, ef});
        chk("x32_illegal", {63'd0, ill32}, {63'd0, ef == 3'd7});
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF00093; out_ready = 1'b0;
        f32 = 1'b0; v32 = 1'b1; ins32 = 32'h00100093; ordy32 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_imm", out_imm, 64'd0);
        chk("rst_fmt", {61'd0, out_fmt}, 64'd0);
        chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
        chk("rst_instr", {32'd0, out_instr}, 64'd0);
        chk("rst_valid32", {63'd0, ov32}, 64'd0);
        reset_n = 1'b1; in_valid = 1'b0; v32 = 1'b0;
        @(negedge clk);
        model_cmp();

        // Known encodings with fixed expected immediates.
        step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_fmt", {61'd0, out_fmt}, 64'd1);
        step(1'b1, 32'hFE112E23, 1'b1, 1'b0);
        chk("sw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
        chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("beq_fmt", {61'd0, out_fmt}, 64'd3);
        step(1'b1, 32'h800002B7, 1'b1, 1'b0);
        chk("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
        step(1'b1, 32'h001000EF, 1'b1, 1'b0);
        chk("jal_imm", out_imm, 64'h800);
        chk("jal_fmt", {61'd0, out_fmt}, 64'd5);
        step(1'b1, 32'h0000007F, 1'b1, 1'b0);
        chk("ill_fmt", {61'd0, out_fmt}, 64'd7);
        chk("ill_flag", {63'd0, out_illegal}, 64'd1);
        chk("ill_imm", out_imm, 64'd0);
        step(1'b1, 32'h0010009B, 1'b1, 1'b0);
        chk("addiw_imm", out_imm, 64'd1);
        chk("addiw_fmt", {61'd0, out_fmt}, 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: fill output + skid, third held, then drain in order.
        step(1'b1, 32'h00100093, 1'b0, 1'b0);
        step(1'b1, 32'h00200093, 1'b0, 1'b0);
        chk("skid_full_rdy", {63'd0, in_ready}, 64'd0);
        step(1'b1, 32'h00300093, 1'b0, 1'b0);
        chk("hold_instr", {32'd0, out_instr}, 64'h00100093);
        step(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("drain1", {32'd0, out_instr}, 64'h00200093);
        step(1'b1, 32'h00300093, 1'b1, 1'b0);
        chk("drain2", {32'd0, out_instr}, 64'h00300093);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with skid full and a transfer offered in the same cycle.
        step(1'b1, 32'h00500093, 1'b0, 1'b0);
        step(1'b1, 32'h00600093, 1'b0, 1'b0);
        step(1'b1, 32'h00700093, 1'b0, 1'b1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_rdy", {63'd0, in_ready}, 64'd1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic with backpressure and occasional flush.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // XLEN=32, no skid.
        step32(32'h800002B7);
        chk("lui32_imm", {32'd0, imm32}, 64'h8000_0000);
        step32(32'h0010009B);
        chk("addiw32_fmt", {61'd0, fmt32}, 64'd7);
        step32(32'hFFF00093);
        step32(32'hFE000CE3);
        step32(32'h0000003B);
        for (int i = 0; i < 40; i++) step32(rand_instr());
        v32 = 1'b1; ins32 = 32'h00100093; ordy32 = 1'b0;
        @(negedge clk);
        chk("x32_stall_rdy", {63'd0, rdy32}, 64'd0);
        ordy32 = 1'b1;
        #1;
        chk("x32_comb_rdy", {63'd0, rdy32}, 64'd1);
        v32 = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
